// File: rtl/iw_regbank_if.sv
`default_nettype none
// ============================================================================
//  Module      : iw_regbank_if
//  Description : Write/read bus bundle for iw_regbank (handshake, modes, views).
//  Revision    : 1.0 - initial release
// ============================================================================
interface iw_regbank_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   wr_mode;
    logic [AW-1:0]          wr_addr;
    logic                   clear;
    logic                   commit;
    logic [AW-1:0]          rd_addr;
    logic [WIDTH-1:0]       rd_data;
    logic [WIDTH*DEPTH-1:0] regs;
    logic [DEPTH-1:0]       loaded;
    logic                   full;
    logic                   err;

    modport master (
        output in_valid, in_data, wr_mode, wr_addr, clear, commit, rd_addr,
        input  in_ready, rd_data, regs, loaded, full, err
    );

    modport slave (
        input  in_valid, in_data, wr_mode, wr_addr, clear, commit, rd_addr,
        output in_ready, rd_data, regs, loaded, full, err
    );
endinterface
`default_nettype wire

// File: rtl/iw_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : iw_regbank
//  Description : Register bank filled sequentially or by address, with
//                written-since-clear tracking. Define IW_REGBANK_SHADOW_EN to
//                stage writes in a shadow bank copied to the active bank on commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module iw_regbank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire             clk,
    input  wire             rst_n,
    iw_regbank_if.slave     bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   c_depth_ext = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last      = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_active [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic             r_full;
    logic             r_err;
    logic [DEPTH-1:0] r_loaded;

    logic             w_ready;
    logic             w_accept;
    logic [AW-1:0]    w_idx;
    logic             w_in_range;
    logic             w_we;
    logic             w_drop;

    always_comb begin
        w_ready    = bus.wr_mode ? !bus.clear : (!r_full && !bus.clear);
        w_accept   = bus.in_valid && w_ready;
        w_idx      = bus.wr_mode ? bus.wr_addr : r_wr_ptr;
        w_in_range = ({1'b0, w_idx} < c_depth_ext);
        w_we       = w_accept && w_in_range;
        w_drop     = w_accept && !w_in_range;
    end

    // Fill tracking; clear blocks acceptance, so it never races a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_full   <= 1'b0;
            r_err    <= 1'b0;
            r_loaded <= '0;
        end else begin
            r_err <= w_drop;
            if (bus.clear) begin
                r_wr_ptr <= '0;
                r_full   <= 1'b0;
                r_loaded <= '0;
            end else if (w_we) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_idx == AW'(i)) begin
                        r_loaded[i] <= 1'b1;
                    end
                end
                if (!bus.wr_mode) begin
                    if (r_wr_ptr == c_last) begin
                        r_wr_ptr <= '0;
                        r_full   <= 1'b1;
                    end else begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                end
            end
        end
    end

`ifdef IW_REGBANK_SHADOW_EN
    logic [WIDTH-1:0] r_shadow [DEPTH];

    // Commit samples the shadow before this cycle's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we && (w_idx == AW'(i))) begin
                    r_shadow[i] <= bus.in_data;
                end
                if (bus.commit) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end
`else
    logic w_unused_commit;
    assign w_unused_commit = bus.commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we && (w_idx == AW'(i))) begin
                    r_active[i] <= bus.in_data;
                end
            end
        end
    end
`endif

    // Out-of-range read addresses match no register and fall through to zero.
    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rd_addr == AW'(i)) begin
                bus.rd_data = r_active[i];
            end
        end
    end

    always_comb begin
        bus.regs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.regs[i*WIDTH +: WIDTH] = r_active[i];
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.loaded   = r_loaded;
    assign bus.full     = r_full;
    assign bus.err      = r_err;
endmodule
`default_nettype wire

// File: tb/tb_iw_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iw_regbank
//  Description : Self-checking bench for iw_regbank (DEPTH=4 and DEPTH=5).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iw_regbank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    iw_regbank_if #(.WIDTH(16), .DEPTH(4)) bus4 ();
    iw_regbank_if #(.WIDTH(16), .DEPTH(5)) bus5 ();

    iw_regbank #(.WIDTH(16), .DEPTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    iw_regbank #(.WIDTH(16), .DEPTH(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

    // Reference model of the DEPTH=4 instance
    bit [15:0] m_sh  [4];
    bit [15:0] m_act [4];
    int        m_ptr;
    bit        m_full;
    bit        m_err;
    bit [3:0]  m_loaded;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_regs();
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = m_act[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_ptr = 0; m_full = 0; m_err = 0; m_loaded = '0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".regs"},   {16'h0, bus4.regs},   {16'h0, m_regs()});
        chk({tag, ".loaded"}, {76'h0, bus4.loaded}, {76'h0, m_loaded});
        chk({tag, ".full"},   {79'h0, bus4.full},   {79'h0, m_full});
        chk({tag, ".err"},    {79'h0, bus4.err},    {79'h0, m_err});
    endtask

    // One clock of the DEPTH=4 instance; entered 1ns after a rising edge.
    task automatic tick(input string tag);
        bit        rdy, acc;
        int        idx;
        bit [15:0] old_sh [4];
        rdy = !bus4.clear && (bus4.wr_mode || !m_full);
        #1;
        chk({tag, ".in_ready"}, {79'h0, bus4.in_ready}, {79'h0, rdy});
        chk({tag, ".rd_data"},  {64'h0, bus4.rd_data},  {64'h0, m_act[int'(bus4.rd_addr)]});
        @(posedge clk);
        acc    = bus4.in_valid && rdy;
        old_sh = m_sh;
        m_err  = 0;
        if (bus4.clear) begin
            m_ptr = 0; m_full = 0; m_loaded = '0;
        end else if (acc) begin
            idx = bus4.wr_mode ? int'(bus4.wr_addr) : m_ptr;
            m_sh[idx]     = bus4.in_data;
            m_loaded[idx] = 1'b1;
            if (!bus4.wr_mode) begin
                m_ptr++;
                if (m_ptr == 4) begin
                    m_ptr = 0; m_full = 1;
                end
            end
        end
`ifdef IW_REGBANK_SHADOW_EN
        if (bus4.commit) m_act = old_sh;
`else
        m_act = m_sh;
`endif
        #1;
        check_state(tag);
    endtask

    task automatic set4(input bit v, input bit mode, input bit [1:0] addr,
                        input bit [15:0] data, input bit clr, input bit cmt);
        bus4.in_valid = v;   bus4.wr_mode = mode; bus4.wr_addr = addr;
        bus4.in_data  = data; bus4.clear  = clr;  bus4.commit  = cmt;
    endtask

    initial begin
        set4(0, 0, 0, 0, 0, 0);
        bus4.rd_addr = '0;
        bus5.in_valid = 0; bus5.wr_mode = 0; bus5.wr_addr = '0; bus5.in_data = '0;
        bus5.clear = 0; bus5.commit = 0; bus5.rd_addr = '0;
        model_reset();

        // Reset state before any clock edge
        #3;
        check_state("reset");
        chk("reset.rd_data", {64'h0, bus4.rd_data}, 80'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Sequential fill with valid held high
        for (int k = 1; k <= 4; k++) begin
            set4(1, 0, 0, 16'(16'h1111 * k), 0, 0);
            tick("fill");
        end
        chk("fill.full", {79'h0, bus4.full}, 80'h1);
        set4(1, 0, 0, 16'h5555, 0, 0);
        tick("fill.blocked");
        chk("fill.in_ready", {79'h0, bus4.in_ready}, 80'h0);
        set4(0, 0, 0, 0, 0, 1);
        tick("fill.commit");
        chk("fill.regs", {16'h0, bus4.regs}, {16'h0, 64'h4444_3333_2222_1111});

        // Clear, then restart the fill at register 0
        set4(0, 0, 0, 0, 1, 0);
        tick("clear");
        set4(1, 0, 0, 16'hAAAA, 0, 0);
        tick("clear.write");
        set4(0, 0, 0, 0, 0, 1);
        tick("clear.commit");
        chk("clear.regs",   {16'h0, bus4.regs},   {16'h0, 64'h4444_3333_2222_AAAA});
        chk("clear.loaded", {76'h0, bus4.loaded}, 80'h1);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            set4($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 16'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
            bus4.rd_addr = 2'($urandom_range(0, 3));
            tick("rand");
        end

        // Reset mid-fill discards the partial sequence
        set4(0, 0, 0, 0, 1, 0);
        tick("mid.clear");
        set4(1, 0, 0, 16'h0101, 0, 0);
        tick("mid.w0");
        set4(1, 0, 0, 16'h0202, 0, 1);
        tick("mid.w1");
        set4(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("mid.reset");
        chk("mid.rd_data", {64'h0, bus4.rd_data}, 80'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus4.rd_addr = 2'd0;
        set4(1, 0, 0, 16'h7777, 0, 0);
        tick("mid.after");
        set4(0, 0, 0, 0, 0, 1);
        tick("mid.commit");
        chk("mid.reg0", {64'h0, bus4.regs[15:0]}, {64'h0, 16'h7777});
        chk("mid.loaded", {76'h0, bus4.loaded}, 80'h1);

        // Addressed write to register 2, visible after commit
        bus4.rd_addr = 2'd2;
        set4(1, 1, 2, 16'hBEEF, 0, 0);
        tick("addr.write");
        set4(0, 0, 0, 0, 0, 1);
        tick("addr.commit");
        set4(0, 0, 0, 0, 0, 0);
        tick("addr.idle");
        chk("addr.rd_data", {64'h0, bus4.rd_data}, {64'h0, 16'hBEEF});

        // DEPTH=5: out-of-range addressed write is dropped with a one-cycle err
        bus5.wr_mode = 1; bus5.wr_addr = 3'd6; bus5.in_data = 16'h1234; bus5.in_valid = 1;
        @(posedge clk); #1;
        bus5.in_valid = 0;
        chk("d5.err_hi", {79'h0, bus5.err},    80'h1);
        chk("d5.regs",   bus5.regs,            80'h0);
        chk("d5.loaded", {75'h0, bus5.loaded}, 80'h0);
        @(posedge clk); #1;
        chk("d5.err_lo", {79'h0, bus5.err},    80'h0);
        bus5.wr_addr = 3'd4; bus5.in_data = 16'h5A5A; bus5.in_valid = 1;
        @(posedge clk); #1;
        bus5.in_valid = 0; bus5.commit = 1;
        @(posedge clk); #1;
        bus5.commit = 0;
        chk("d5.reg4",   bus5.regs, {16'h5A5A, 64'h0});
        chk("d5.loaded4", {75'h0, bus5.loaded}, {75'h0, 5'b10000});
        bus5.rd_addr = 3'd5;
        #1;
        chk("d5.rd_oor", {64'h0, bus5.rd_data}, 80'h0);
        bus5.rd_addr = 3'd4;
        #1;
        chk("d5.rd4",    {64'h0, bus5.rd_data}, {64'h0, 16'h5A5A});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/iw_regbank.md
IW_REGBANK -- requirements
Module: iw_regbank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bit width of every register and data port.
REQ-002 SHALL have parameter DEPTH, default 4 (min 2), meaning number of registers.
REQ-003 SHALL have derived parameter AW = max(1, clog2(DEPTH)), meaning address width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  write request.
REQ-007 SHALL have port in_ready  output  1  write accept.
REQ-008 SHALL have port in_data  input  WIDTH  write data.
REQ-009 SHALL have port wr_mode  input  1  0 = sequential auto-increment, 1 = addressed.
REQ-010 SHALL have port wr_addr  input  AW  target register in addressed mode.
REQ-011 SHALL have port clear  input  1  synchronous restart of the fill sequence.
REQ-012 SHALL have port commit  input  1  shadow-to-active copy pulse.
REQ-013 SHALL have port rd_addr  input  AW  read select.
REQ-014 SHALL have port rd_data  output  WIDTH  active register at rd_addr.
REQ-015 SHALL have port regs  output  WIDTH*DEPTH  all active registers flattened, register 0 in LSBs.
REQ-016 SHALL have port loaded  output  DEPTH  per-register written-since-clear flags.
REQ-017 SHALL have port full  output  1  sequential fill complete.
REQ-018 SHALL have port err  output  1  one-cycle pulse on a dropped out-of-range write.

Function
REQ-019 SHALL accept a write only in a cycle where in_valid and in_ready are both 1.
REQ-020 SHALL, in sequential mode, write register wr_ptr, then increment wr_ptr; the write to register DEPTH-1 sets full and wraps wr_ptr to 0.
REQ-021 SHALL drive in_ready = !full && !clear in sequential mode, and in_ready = !clear in addressed mode.
REQ-022 SHALL, in addressed mode, write register wr_addr and leave wr_ptr and full unchanged.
REQ-023 SHALL drop an accepted addressed write with wr_addr >= DEPTH, leave state unchanged, and pulse err for the following cycle.
REQ-024 SHALL set loaded[i] on every accepted in-range write to register i.
REQ-025 SHALL, on clear, zero wr_ptr, full and loaded in the next cycle and retain register contents.
REQ-026 SHALL make a written value visible on regs and rd_data one cycle after acceptance; rd_data SHALL be combinational from the active bank.
REQ-027 SHALL return 0 on rd_data when rd_addr >= DEPTH.
REQ-028 SHALL let wr_mode change between any two cycles without corrupting wr_ptr.

Reset
REQ-029 SHALL, while rst_n is 0, clear all registers (active and shadow), wr_ptr, loaded, full and err to 0, independent of clk.
REQ-030 SHALL, on reset asserted mid-fill, discard the partial fill so that the next sequential write after release targets register 0.

Configuration
REQ-031 SHALL compile in a shadow bank when macro IW_REGBANK_SHADOW_EN is defined: accepted writes and loaded/full/err tracking update the shadow bank only, and commit copies the full shadow bank to the active bank in one cycle.
REQ-032 SHALL, with IW_REGBANK_SHADOW_EN defined, give the active bank the pre-write shadow contents when commit and a write coincide; the write SHALL land in shadow only.
REQ-033 SHALL, without IW_REGBANK_SHADOW_EN, write the active bank directly, keep the commit port, and ignore it.

Verification
REQ-034 SHALL cover: WIDTH=16, DEPTH=4, sequential writes 0x1111..0x4444 with in_valid held high -> regs = 0x4444_3333_2222_1111, full = 1 after the 4th write, in_ready = 0 from then on.
REQ-035 SHALL cover: full = 1, then clear = 1 for one cycle, then write 0xAAAA -> register 0 = 0xAAAA, loaded = 4'b0001, other registers retained.
REQ-036 SHALL cover: DEPTH=5, addressed write to wr_addr = 6 -> no register change, err = 1 for exactly one cycle.
REQ-037 SHALL cover: shadow enabled, write 0xBEEF to register 2 -> active register 2 stays 0 until commit; the cycle after commit rd_data(rd_addr = 2) = 0xBEEF.
REQ-038 SHALL cover: rst_n asserted after 2 of 4 sequential writes -> all outputs 0 immediately; after release, the next write lands in register 0.
